// File: rtl/lcd_console_pkg.sv
// Shared constants, control codes and FSM states for the LCD character console.
// LCD_CONSOLE_CLEAR_EN adds the screen/row clear states.
package lcd_console_pkg;

    localparam int COLUMNS       = 60;
    localparam int ROWS          = 17;
    localparam int WORDS_PER_ROW = COLUMNS / 4;
    localparam int TOTAL_WORDS   = COLUMNS * ROWS / 4;

    localparam logic [7:0] CHAR_BS   = 8'h08;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_FF   = 8'h0C;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;
    localparam logic [7:0] FONT_BASE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP
`ifdef LCD_CONSOLE_CLEAR_EN
        ,
        CLEAR,
        CLEAR_GAP
`endif
    } state_e;

    // First screen-memory word of a character row.
    function automatic logic [7:0] row_first_word(input logic [4:0] r);
        return 8'(int'(r) * WORDS_PER_ROW);
    endfunction

endpackage

// File: rtl/lcd_console_bus_master.sv
// Single-outstanding write master: latches a request on start and holds it
// on the bus until the slave returns ready.
module lcd_console_bus_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  addr,
    input  logic [31:0] data,
    input  logic [3:0]  wstrb,
    input  logic        bus_ready,
    output logic        bus_select,
    output logic [9:0]  bus_addr,
    output logic [31:0] bus_data,
    output logic [3:0]  bus_wstrb,
    output logic        done
);

    logic        sel_q, sel_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  wstrb_q, wstrb_d;

    assign done = sel_q & bus_ready;

    always_comb begin
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wstrb_d = wstrb_q;
        if (start) begin
            sel_d   = 1'b1;
            addr_d  = addr;
            data_d  = data;
            wstrb_d = wstrb;
        end else if (done) begin
            sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wstrb_q <= '0;
        end else begin
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign bus_select = sel_q;
    assign bus_addr   = addr_q;
    assign bus_data   = data_q;
    assign bus_wstrb  = wstrb_q;

endmodule

// File: rtl/lcd_console.sv
// Byte-stream console: cursor tracking and control-code handling in front of the
// screen-memory write port. LCD_CONSOLE_CLEAR_EN enables form-feed/row clearing.
module lcd_console
    import lcd_console_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        bus_select,
    output logic [3:0]  bus_wstrb,
    output logic [9:0]  bus_addr,
    output logic [31:0] bus_data,
    input  logic        bus_ready,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [5:0]  col_q, col_d, pcol_q, pcol_d;
    logic [4:0]  row_q, row_d, prow_q, prow_d;
    logic        start, done, printable;
    logic [9:0]  m_addr, offset, bs_offset;
    logic [31:0] m_data;
    logic [3:0]  m_wstrb;
    logic [7:0]  glyph;
    logic [4:0]  row_adv;
`ifdef LCD_CONSOLE_CLEAR_EN
    logic [7:0]  clr_idx_q, clr_idx_d, clr_last_q, clr_last_d;
    logic        pclr_q, pclr_d, ff_q, ff_d;
`endif

    assign offset    = 10'(row_q) * 10'(COLUMNS) + 10'(col_q);
    assign bs_offset = offset - 10'd1;
    assign glyph     = {1'b0, 7'(in_data - FONT_BASE)};
    assign printable = (in_data >= PRINT_MIN) && (in_data <= PRINT_MAX);
    assign row_adv   = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        start   = 1'b0;
        m_addr  = offset;
        m_data  = {4{glyph}};
        m_wstrb = 4'b0001 << offset[1:0];
`ifdef LCD_CONSOLE_CLEAR_EN
        clr_idx_d  = clr_idx_q;
        clr_last_d = clr_last_q;
        pclr_d     = pclr_q;
        ff_d       = ff_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                if (printable) begin
                    start   = 1'b1;
                    state_d = WRITE;
                    if (col_q == 6'(COLUMNS - 1)) begin
                        pcol_d = 6'd0;
                        prow_d = row_adv;
`ifdef LCD_CONSOLE_CLEAR_EN
                        pclr_d = 1'b1;
`endif
                    end else begin
                        pcol_d = col_q + 6'd1;
                        prow_d = row_q;
                    end
                end else if (in_data == CHAR_LF) begin
                    col_d = 6'd0;
                    row_d = row_adv;
`ifdef LCD_CONSOLE_CLEAR_EN
                    start      = 1'b1;
                    state_d    = CLEAR;
                    clr_idx_d  = row_first_word(row_adv);
                    clr_last_d = clr_idx_d + 8'(WORDS_PER_ROW - 1);
                    m_addr     = {clr_idx_d, 2'b00};
                    m_data     = '0;
                    m_wstrb    = 4'hF;
`endif
                end else if (in_data == CHAR_CR) begin
                    col_d = 6'd0;
                end else if (in_data == CHAR_BS) begin
                    if (col_q != 6'd0) begin
                        start   = 1'b1;
                        state_d = WRITE;
                        pcol_d  = col_q - 6'd1;
                        prow_d  = row_q;
                        m_addr  = bs_offset;
                        m_data  = '0;
                        m_wstrb = 4'b0001 << bs_offset[1:0];
                    end
                end else if (in_data == CHAR_FF) begin
`ifdef LCD_CONSOLE_CLEAR_EN
                    start      = 1'b1;
                    state_d    = CLEAR;
                    ff_d       = 1'b1;
                    clr_idx_d  = 8'd0;
                    clr_last_d = 8'(TOTAL_WORDS - 1);
                    m_addr     = '0;
                    m_data     = '0;
                    m_wstrb    = 4'hF;
`else
                    col_d = 6'd0;
                    row_d = 5'd0;
`endif
                end
            end
            WRITE: if (done) begin
                col_d   = pcol_q;
                row_d   = prow_q;
                state_d = GAP;
            end
            GAP: begin
`ifdef LCD_CONSOLE_CLEAR_EN
                // row_q already holds the row the wrapped write landed on
                if (pclr_q) begin
                    pclr_d     = 1'b0;
                    start      = 1'b1;
                    state_d    = CLEAR;
                    clr_idx_d  = row_first_word(row_q);
                    clr_last_d = clr_idx_d + 8'(WORDS_PER_ROW - 1);
                    m_addr     = {clr_idx_d, 2'b00};
                    m_data     = '0;
                    m_wstrb    = 4'hF;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
`ifdef LCD_CONSOLE_CLEAR_EN
            CLEAR: if (done) state_d = CLEAR_GAP;
            CLEAR_GAP: begin
                if (clr_idx_q == clr_last_q) begin
                    state_d = IDLE;
                    if (ff_q) begin
                        col_d = 6'd0;
                        row_d = 5'd0;
                        ff_d  = 1'b0;
                    end
                end else begin
                    clr_idx_d = clr_idx_q + 8'd1;
                    start     = 1'b1;
                    state_d   = CLEAR;
                    m_addr    = {clr_idx_d, 2'b00};
                    m_data    = '0;
                    m_wstrb   = 4'hF;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pcol_q  <= '0;
            prow_q  <= '0;
`ifdef LCD_CONSOLE_CLEAR_EN
            clr_idx_q  <= '0;
            clr_last_q <= '0;
            pclr_q     <= 1'b0;
            ff_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
`ifdef LCD_CONSOLE_CLEAR_EN
            clr_idx_q  <= clr_idx_d;
            clr_last_q <= clr_last_d;
            pclr_q     <= pclr_d;
            ff_q       <= ff_d;
`endif
        end
    end

    lcd_console_bus_master u_master (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr       (m_addr),
        .data       (m_data),
        .wstrb      (m_wstrb),
        .bus_ready  (bus_ready),
        .bus_select (bus_select),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_wstrb  (bus_wstrb),
        .done       (done)
    );

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_lcd_console.sv
// Directed bench for lcd_console: vector table plus wrap, clear and reset sequences.
// Expectations follow LCD_CONSOLE_CLEAR_EN when it is defined for the build.
module tb_lcd_console;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, bus_select, bus_ready, busy;
    logic [7:0]  in_data;
    logic [3:0]  bus_wstrb;
    logic [9:0]  bus_addr;
    logic [31:0] bus_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;

    int checks = 0;
    int errors = 0;
    int slv_wait = 0;
    int slv_cnt;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_strb[$];

    typedef struct {
        logic [7:0]  ch;
        int          nwr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic [5:0]  col;
        logic [4:0]  row;
    } vec_t;
    vec_t vecs[12];

    lcd_console dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bus_select (bus_select),
        .bus_wstrb  (bus_wstrb),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_ready  (bus_ready),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Registered-ready slave with programmable extra wait cycles.
    always @(posedge clk) begin
        if (rst || !bus_select) begin
            slv_cnt   <= 0;
            bus_ready <= 1'b0;
        end else if (bus_ready) begin
            bus_ready <= 1'b0;
        end else if (slv_cnt >= slv_wait) begin
            bus_ready <= 1'b1;
        end else begin
            slv_cnt <= slv_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && bus_select && bus_ready) begin
            wr_addr.push_back(bus_addr);
            wr_data.push_back(bus_data);
            wr_strb.push_back(bus_wstrb);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request must stay put while the slave has not answered.
    logic        hold_prev = 1'b0;
    logic [9:0]  h_addr;
    logic [31:0] h_data;
    logic [3:0]  h_strb;
    always @(negedge clk) begin
        if (hold_prev && bus_select) begin
            check("hold_addr", bus_addr, h_addr);
            check("hold_data", bus_data, h_data);
            check("hold_wstrb", bus_wstrb, h_strb);
        end
        hold_prev = bus_select && !bus_ready && !rst;
        h_addr = bus_addr;
        h_data = bus_data;
        h_strb = bus_wstrb;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_strb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy stayed 1 expected 0");
        end
    endtask

    initial begin
        int lo, sel;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;

        vecs[0]  = '{8'h41, 1, 10'd0,  32'h21212121, 4'h1, 6'd1, 5'd0};
        vecs[1]  = '{8'h42, 1, 10'd1,  32'h22222222, 4'h2, 6'd2, 5'd0};
        vecs[2]  = '{8'h0D, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd0};
`ifdef LCD_CONSOLE_CLEAR_EN
        vecs[3]  = '{8'h0A, 15, 10'd116, 32'h0,      4'hF, 6'd0, 5'd1};
`else
        vecs[3]  = '{8'h0A, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd1};
`endif
        vecs[4]  = '{8'h7E, 1, 10'd60, 32'h5E5E5E5E, 4'h1, 6'd1, 5'd1};
        vecs[5]  = '{8'h08, 1, 10'd60, 32'h0,        4'h1, 6'd0, 5'd1};
        vecs[6]  = '{8'h08, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd1};
        vecs[7]  = '{8'h7F, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd1};
        vecs[8]  = '{8'h00, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd1};
        vecs[9]  = '{8'hFF, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd1};
        vecs[10] = '{8'h20, 1, 10'd60, 32'h0,        4'h1, 6'd1, 5'd1};
`ifdef LCD_CONSOLE_CLEAR_EN
        vecs[11] = '{8'h0C, 255, 10'd1016, 32'h0,    4'hF, 6'd0, 5'd0};
`else
        vecs[11] = '{8'h0C, 0, 10'd0,  32'h0,        4'h0, 6'd0, 5'd0};
`endif

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_select", bus_select, 0);
        check("rst_wstrb", bus_wstrb, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_data", bus_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);

        // First printable byte: ready gap and select width
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        in_valid = 1'b0;
        lo = 0;
        sel = 0;
        while (!in_ready && lo < 20) begin
            if (bus_select) sel++;
            lo++;
            @(negedge clk);
        end
        check("a_ready_low_cycles", lo, 3);
        check("a_select_cycles", sel, 2);
        check("a_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            check("a_addr", wr_addr[0], 0);
            check("a_wstrb", wr_strb[0], 4'b0001);
            check("a_data", wr_data[0], 32'h21212121);
        end
        check("a_col", cursor_col, 1);
        check("a_row", cursor_row, 0);

        // Vector table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            clear_log();
            send(vecs[i].ch);
            wait_idle();
            check($sformatf("v%0d_nwr", i), wr_addr.size(), vecs[i].nwr);
            if (vecs[i].nwr > 0 && wr_addr.size() > 0) begin
                check($sformatf("v%0d_addr", i), wr_addr[$], vecs[i].addr);
                check($sformatf("v%0d_data", i), wr_data[$], vecs[i].data);
                check($sformatf("v%0d_wstrb", i), wr_strb[$], vecs[i].wstrb);
            end
            check($sformatf("v%0d_col", i), cursor_col, vecs[i].col);
            check($sformatf("v%0d_row", i), cursor_row, vecs[i].row);
        end

        // Column wrap at 0/59
        do_reset();
        for (int i = 0; i < 59; i++) begin
            send(8'h21);
            wait_idle();
        end
        check("w_pre_col", cursor_col, 59);
        clear_log();
        send(8'h42);
        wait_idle();
`ifdef LCD_CONSOLE_CLEAR_EN
        check("w_nwr", wr_addr.size(), 16);
        if (wr_addr.size() == 16) check("w_clr_last", wr_addr[15], 116);
`else
        check("w_nwr", wr_addr.size(), 1);
`endif
        if (wr_addr.size() > 0) begin
            check("w_addr", wr_addr[0], 59);
            check("w_wstrb", wr_strb[0], 4'b1000);
            check("w_data", wr_data[0], 32'h22222222);
        end
        check("w_col", cursor_col, 0);
        check("w_row", cursor_row, 1);

        // Slow slave: request held through wait cycles
        slv_wait = 3;
        clear_log();
        send(8'h43);
        wait_idle();
        slv_wait = 0;
        check("s_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            check("s_addr", wr_addr[0], 60);
            check("s_data", wr_data[0], 32'h23232323);
        end
        check("s_col", cursor_col, 1);

        // Row wrap from 16 to 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(8'h0A);
            wait_idle();
        end
        check("r_pre_row", cursor_row, 16);
        clear_log();
        send(8'h0A);
        wait_idle();
`ifdef LCD_CONSOLE_CLEAR_EN
        check("r_nwr", wr_addr.size(), 15);
        if (wr_addr.size() == 15) begin
            check("r_first", wr_addr[0], 0);
            check("r_last", wr_addr[14], 56);
            check("r_wstrb", wr_strb[7], 4'hF);
        end
`else
        check("r_nwr", wr_addr.size(), 0);
`endif
        check("r_col", cursor_col, 0);
        check("r_row", cursor_row, 0);

        // Reset during a write
        do_reset();
        send(8'h0D);
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        in_valid = 1'b0;
        check("x_select_before", bus_select, 1);
        rst = 1'b1;
        @(negedge clk);
        check("x_select", bus_select, 0);
        check("x_in_ready", in_ready, 1);
        check("x_col", cursor_col, 0);
        check("x_row", cursor_row, 0);
        rst = 1'b0;
        clear_log();
        send(8'h7F);
        wait_idle();
        send(8'h00);
        wait_idle();
        repeat (5) @(negedge clk);
        check("x_nwr", wr_addr.size(), 0);
        check("x_col_after", cursor_col, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_console.md
# lcd_console

Character-stream front end for the LCD text layer. Accepts ASCII bytes over a valid/ready stream, tracks a cursor, and turns each byte into a byte-strobed write on the ASCII screen-memory bus port of the LCD block. The CPU can then emit text one byte at a time instead of computing screen offsets. It handles newline, carriage return, backspace, line wrap, row wrap and clearing.

## Interface
- COLUMNS, 60: character columns per row. Must be a multiple of 4.
- ROWS, 17: character rows.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte (ASCII).
- in_ready  out  1  byte accepted when in_valid & in_ready at a rising clk edge.
- bus_select  out  1  write request to screen memory (drives ascii_select).
- bus_wstrb  out  4  byte strobes; never 0 while bus_select is high.
- bus_addr  out  10  byte address into screen memory.
- bus_data  out  32  write data.
- bus_ready  in  1  slave ready; registered, follows bus_select by ≥1 cycle.
- cursor_col  out  6  current column, 0..COLUMNS-1.
- cursor_row  out  5  current row, 0..ROWS-1.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, WRITE, GAP, CLEAR, CLEAR_GAP.
- in_ready is high only in IDLE.
- Printable byte 0x20..0x7E:
  - Stored byte is {1'b0, in_data-7'h20}; bit 7 (colour) is always 0.
  - Byte offset = row*COLUMNS+col. bus_addr = offset, bus_wstrb = 1<<offset[1:0], stored byte replicated on all four lanes.
  - After the write, col increments. At COLUMNS-1, col goes to 0 and the row advances.
- 0x0A: col←0, row advances, no write.
- 0x0D: col←0, no write.
- 0x08: if col>0, col decrements and a space (stored 0x00) is written at the new position. If col==0, no-op.
- 0x0C: form feed; see Configuration.
- Every other byte (0x00..0x1F not listed, 0x7F..0xFF) is consumed and ignored, no write.
- Row advance: row+1, or 0 from ROWS-1. Row clear on wrap is described under Configuration.
- Bus handshake:
  - bus_select, bus_addr, bus_data and bus_wstrb are held stable until bus_ready is sampled high.
  - bus_select drops in the next cycle; the FSM then spends one GAP cycle with bus_select low and ignores bus_ready.
  - This absorbs the slave's trailing ready cycle.
- Clear sequence:
  - Word writes: bus_wstrb=4'hF, bus_data=0, bus_addr = word index <<2, indices ascending.
  - Each word is followed by one CLEAR_GAP cycle.
- Reset: any state returns to IDLE at the next edge. Outputs after reset: bus_select=0, bus_wstrb=0, bus_addr=0, bus_data=0, in_ready=1, busy=0, cursor 0/0. No clear is issued on reset.
- A bus transaction interrupted by rst is abandoned and not retried.

## Timing
- Byte accepted at edge T (single-cycle-ready slave):
  - Printable: bus_select high in cycles T+1..T+2, bus_ready seen at T+2, GAP in T+3, in_ready high again in T+4.
  - Ignored and cursor-only bytes: in_ready high again in T+1. Cursor updates are visible in T+1.
- Cursor outputs update in the cycle after bus_ready is sampled for a write. They update in the cycle after acceptance for non-writing codes.
- Full clear = COLUMNS*ROWS/4 words × 3 cycles (765 cycles at defaults). Row clear = COLUMNS/4 words × 3 cycles (45 cycles).
- Throughput with continuous in_valid: one printable byte per 4 cycles.

## Configuration
- LCD_CONSOLE_CLEAR_EN defined:
  - 0x0C clears the whole screen (word indices 0..COLUMNS*ROWS/4-1) and then sets the cursor to 0/0.
  - A row advance that wraps ROWS-1→0 clears row 0 (words 0..COLUMNS/4-1) before returning to IDLE. Any row advance landing on a row r clears that row's words r*COLUMNS/4..+COLUMNS/4-1.
- Undefined:
  - 0x0C only resets the cursor to 0/0.
  - Row advances never write.
  - CLEAR and CLEAR_GAP states are absent.

## Structure
- Package lcd_console_pkg holds:
  - COLUMNS and ROWS defaults and the derived WORDS_PER_ROW and TOTAL_WORDS.
  - Control-code constants CHAR_BS, CHAR_LF, CHAR_FF, CHAR_CR, the printable-range bounds, and FONT_BASE=8'h20.
  - The FSM state enum.
- Sub-module lcd_console_bus_master owns the select/hold/gap handshake. It takes start, addr, data and wstrb, and returns done.

## Test plan
- Reset, then "A" (0x41): one write with addr 0, wstrb 4'b0001, data 32'h21212121. Cursor becomes 0/1. in_ready is low for exactly 3 cycles.
- Cursor at 0/59, send 0x42: write at addr 59, wstrb 4'b1000. Cursor becomes 1/0.
- Send 0x41, 0x08: second write at addr 0 with data 0. Cursor 0/0. Another 0x08 issues no bus activity.
- Cursor at row 16, send 0x0A, with LCD_CONSOLE_CLEAR_EN defined: 15 word writes to addr 0,4,..,56 with wstrb 4'hF. Cursor becomes 0/0.
- 0x0C with LCD_CONSOLE_CLEAR_EN defined: 255 word writes, last at addr 1016. Without the macro: no writes, cursor 0/0.
- Assert rst in the middle of a write while bus_select is high: bus_select=0 and in_ready=1 at the next edge. Cursor 0/0. Feeding 0x7F or 0x00 after that produces no writes.
